urna_parametrizada: RTL
=======================

URNA_PARAMETRIZADA -- requirements
Module: urna_parametrizada

Interface
REQ-001 Parameter NUM_CAND, default 4, number of candidate channels (2..16).
REQ-002 Parameter DIGITS, default 4, BCD digits per vote code (1..6).
REQ-003 Parameter CNT_W, default 8, width of every vote counter.
REQ-004 Parameter CAND_CODES, default {16'h3509,16'h3502,16'h3492,16'h3474}, packed NUM_CAND*DIGITS*4 bits; candidate 0 in the LSBs; first-entered digit is the most significant nibble of each code.
REQ-005 clock  input  1  rising-edge clock; single clock domain.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 valid  input  1  one digit presented on digit this cycle.
REQ-008 digit  input  4  digit value; 4'hC = cancel.
REQ-009 finish  input  1  close the election.
REQ-010 clear  input  1  zero all counters and reopen; honoured only while closed.
REQ-011 sel  input  SEL_W=$clog2(NUM_CAND+2)  result select: 0..NUM_CAND-1 candidate, NUM_CAND null, NUM_CAND+1 blank.
REQ-012 vote_ok  output  1  one-cycle pulse per committed vote.
REQ-013 is_open  output  1  election accepting votes.
REQ-014 done  output  1  closed and winner scan complete.
REQ-015 result  output  CNT_W  count selected by sel.
REQ-016 winner  output  SEL_W  index of highest-count candidate.
REQ-017 tie  output  1  another candidate equals the winner's count.

Function
REQ-018 States: COLETA (open), APURA (commit, 1 cycle), VARRE (scan, NUM_CAND cycles), ENCERRADA (closed).
REQ-019 COLETA: each valid cycle with digit != 4'hC shifts digit into entry buffer; digit count increments.
REQ-020 valid with digit 4'hC in COLETA clears buffer and digit count; no vote recorded.
REQ-021 On the DIGITS-th accepted digit, go to APURA next cycle; valid during APURA ignored.
REQ-022 APURA: buffer matching CAND_CODES[i] increments counter i, else null counter increments; vote_ok=1 that cycle; buffer cleared; return to COLETA.
REQ-023 All counters saturate at 2^CNT_W-1; a saturated vote still pulses vote_ok.
REQ-024 finish in COLETA has priority over a simultaneous valid: partial entry (including that digit) discarded; enter VARRE next cycle; is_open=0 from that cycle.
REQ-025 finish in APURA: vote commits, then VARRE.
REQ-026 VARRE: one candidate compared per cycle, index 0 upward; strictly greater replaces best and clears tie; equal sets tie; lowest index wins ties.
REQ-027 done=1 from cycle NUM_CAND+1 after finish sampled, held through ENCERRADA; winner/tie stable while done=1.
REQ-028 All counts zero: winner=0, tie=1.
REQ-029 result is combinational from sel in every state; sel>NUM_CAND+1 (or NUM_CAND+1 without blank feature) gives 0.
REQ-030 valid and finish ignored in VARRE and ENCERRADA; clear ignored outside ENCERRADA.
REQ-031 clear in ENCERRADA: all counters, winner, tie, done zeroed; COLETA and is_open=1 next cycle.

Reset
REQ-032 reset_n low, asynchronously: state COLETA, buffer/digit count/all counters 0, vote_ok=0, done=0, winner=0, tie=0, is_open=1; mid-entry or mid-scan work is discarded.

Configuration
REQ-033 Macro URNA_BRANCO_EN defined: digit 4'hB as first digit of an entry commits a blank vote via APURA (blank counter, vote_ok pulse); 4'hB elsewhere is an ordinary digit.
REQ-034 URNA_BRANCO_EN undefined: no blank counter; 4'hB always an ordinary digit; sel=NUM_CAND+1 gives 0.

Structure
REQ-035 Package urna_pkg: state enum, CANCEL=4'hC, BRANCO=4'hB, default code table.
REQ-036 Sub-module urna_contador: CNT_W saturating counter with inc and synchronous clear, instantiated per candidate, null and blank.

Verification
REQ-037 Digits 3,4,7,4 -> vote_ok one cycle after last digit; sel=0 -> result=1.
REQ-038 Digits 3,5,0,F -> null count 1; candidate counts unchanged.
REQ-039 Digits 3,4,C,3,4,9,2 -> only candidate 1 increments; exactly one vote_ok.
REQ-040 CNT_W=2, five votes 3,5,0,2 -> sel=2 result=3.
REQ-041 Votes 3474 x2, 3509 x2, finish -> done after 5 cycles, winner=0, tie=1; clear -> all results 0, is_open=1.
REQ-042 URNA_BRANCO_EN, digit B -> sel=5 result=1; reset_n pulse after digits 3,4 -> no vote; next 3,4,7,4 counts once.

Source files
------------

// File: rtl/urna_pkg.sv
// urna_pkg: state encoding, special digit codes and the default candidate
// code table shared by urna_parametrizada and urna_contador.
package urna_pkg;

  typedef enum logic [1:0] {
    COLETA    = 2'd0,
    APURA     = 2'd1,
    VARRE     = 2'd2,
    ENCERRADA = 2'd3
  } urna_state_e;

  localparam logic [3:0] CANCEL = 4'hC;
  localparam logic [3:0] BRANCO = 4'hB;

  // Candidate 0 sits in the LSBs; each code is read first-digit-in-MSB.
  localparam logic [63:0] DEFAULT_CODES = {16'h3509, 16'h3502, 16'h3492, 16'h3474};

endpackage

// File: rtl/urna_contador.sv
// urna_contador: CNT_W-bit saturating vote counter with increment and
// synchronous clear; one instance per candidate, null and blank tally.
module urna_contador
  import urna_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, increments stop at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/urna_parametrizada.sv
// urna_parametrizada: parameterised BCD voting machine with tally and winner
// scan. Define URNA_BRANCO_EN to enable blank votes (digit B as first digit).
module urna_parametrizada
  import urna_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int DIGITS   = 4,
  parameter int CNT_W    = 8,
  parameter logic [NUM_CAND*DIGITS*4-1:0] CAND_CODES = DEFAULT_CODES,
  localparam int SEL_W   = $clog2(NUM_CAND + 2)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [3:0]       digit,
  input  logic             finish,
  input  logic             clear,
  input  logic [SEL_W-1:0] sel,
  output logic             vote_ok,
  output logic             is_open,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [SEL_W-1:0] winner,
  output logic             tie
);

  localparam int BUF_W = DIGITS * 4;
  localparam int DCW   = $clog2(DIGITS + 1);
  localparam int IDXW  = $clog2(NUM_CAND);

  urna_state_e      state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [IDXW-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [SEL_W-1:0] winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             done_q, done_d;
  logic             vote_ok_q;
  logic             is_open_q;

  logic [CNT_W-1:0]    cand_cnt_s [NUM_CAND];
  logic [CNT_W-1:0]    null_cnt_s;
  logic [CNT_W-1:0]    scan_cnt_s;
  logic [NUM_CAND-1:0] hit_s;
  logic [NUM_CAND-1:0] cand_inc_s;
  logic                null_inc_s;
  logic                cnt_clr_s;
  logic [CNT_W-1:0]    result_s;
`ifdef URNA_BRANCO_EN
  logic                blank_q, blank_d;
  logic                blank_inc_s;
  logic [CNT_W-1:0]    blank_cnt_s;
`endif

  // Compare the entry buffer against every candidate code.
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) begin
      hit_s[i] = (buf_q == CAND_CODES[i*BUF_W +: BUF_W]);
    end
  end

  assign scan_cnt_s = cand_cnt_s[scan_q];

  // Next-state and datapath control for entry, commit, scan and closed phases.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    dcnt_d     = dcnt_q;
    scan_d     = scan_q;
    best_d     = best_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    done_d     = done_q;
    cand_inc_s = '0;
    null_inc_s = 1'b0;
    cnt_clr_s  = 1'b0;
`ifdef URNA_BRANCO_EN
    blank_d     = blank_q;
    blank_inc_s = 1'b0;
`endif
    case (state_q)
      COLETA: begin
        if (finish) begin
          // Finish beats a simultaneous digit; the partial entry is dropped.
          buf_d   = '0;
          dcnt_d  = '0;
          scan_d  = '0;
          state_d = VARRE;
        end else if (valid) begin
          if (digit == CANCEL) begin
            buf_d  = '0;
            dcnt_d = '0;
          end
`ifdef URNA_BRANCO_EN
          else if ((digit == BRANCO) && (dcnt_q == '0)) begin
            blank_d = 1'b1;
            state_d = APURA;
          end
`endif
          else begin
            buf_d      = buf_q << 4;
            buf_d[3:0] = digit;
            if (dcnt_q == DCW'(DIGITS - 1)) begin
              dcnt_d  = '0;
              state_d = APURA;
            end else begin
              dcnt_d = dcnt_q + DCW'(1);
            end
          end
        end else begin
          state_d = COLETA;
        end
      end
      APURA: begin
`ifdef URNA_BRANCO_EN
        if (blank_q) begin
          blank_inc_s = 1'b1;
        end else if (|hit_s) begin
          cand_inc_s = hit_s;
        end else begin
          null_inc_s = 1'b1;
        end
        blank_d = 1'b0;
`else
        if (|hit_s) begin
          cand_inc_s = hit_s;
        end else begin
          null_inc_s = 1'b1;
        end
`endif
        buf_d  = '0;
        dcnt_d = '0;
        scan_d = '0;
        if (finish) begin
          state_d = VARRE;
        end else begin
          state_d = COLETA;
        end
      end
      VARRE: begin
        // Lowest index keeps the lead on equal counts; equality flags a tie.
        if (scan_q == '0) begin
          best_d   = scan_cnt_s;
          winner_d = '0;
          tie_d    = 1'b0;
        end else if (scan_cnt_s > best_q) begin
          best_d   = scan_cnt_s;
          winner_d = SEL_W'(scan_q);
          tie_d    = 1'b0;
        end else if (scan_cnt_s == best_q) begin
          tie_d = 1'b1;
        end else begin
          tie_d = tie_q;
        end
        if (scan_q == IDXW'(NUM_CAND - 1)) begin
          done_d  = 1'b1;
          state_d = ENCERRADA;
        end else begin
          scan_d = scan_q + IDXW'(1);
        end
      end
      ENCERRADA: begin
        if (clear) begin
          cnt_clr_s = 1'b1;
          best_d    = '0;
          winner_d  = '0;
          tie_d     = 1'b0;
          done_d    = 1'b0;
          state_d   = COLETA;
        end else begin
          state_d = ENCERRADA;
        end
      end
      default: begin
        state_d = COLETA;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= COLETA;
      buf_q     <= '0;
      dcnt_q    <= '0;
      scan_q    <= '0;
      best_q    <= '0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      done_q    <= 1'b0;
      vote_ok_q <= 1'b0;
      is_open_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      dcnt_q    <= dcnt_d;
      scan_q    <= scan_d;
      best_q    <= best_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      done_q    <= done_d;
      vote_ok_q <= (state_d == APURA);
      is_open_q <= (state_d == COLETA) || (state_d == APURA);
    end
  end

`ifdef URNA_BRANCO_EN
  // Pending blank-vote flag carried into the commit cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  urna_contador #(.CNT_W(CNT_W)) u_blank (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr_s),
    .inc_i   (blank_inc_s),
    .count_o (blank_cnt_s)
  );
`endif

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    urna_contador #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr_i   (cnt_clr_s),
      .inc_i   (cand_inc_s[g]),
      .count_o (cand_cnt_s[g])
    );
  end

  urna_contador #(.CNT_W(CNT_W)) u_null (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr_s),
    .inc_i   (null_inc_s),
    .count_o (null_cnt_s)
  );

  // Result select: candidates, then null, then blank when present.
  always_comb begin
    result_s = '0;
    if (sel < SEL_W'(NUM_CAND)) begin
      result_s = cand_cnt_s[sel[IDXW-1:0]];
    end else if (sel == SEL_W'(NUM_CAND)) begin
      result_s = null_cnt_s;
    end
`ifdef URNA_BRANCO_EN
    else if (sel == SEL_W'(NUM_CAND + 1)) begin
      result_s = blank_cnt_s;
    end
`endif
    else begin
      result_s = '0;
    end
  end

  assign result  = result_s;
  assign vote_ok = vote_ok_q;
  assign is_open = is_open_q;
  assign done    = done_q;
  assign winner  = winner_q;
  assign tie     = tie_q;

endmodule
